// File: rtl/serdes_rx_bitslip_aligner.sv
// Bit-slip responder: extracts a 66-bit window at a programmable bit offset from
// a continuous 66-bit block stream, advancing the offset on each bitslip request.
module serdes_rx_bitslip_aligner #(
  parameter int DATA_WIDTH        = 64,
  parameter int HDR_WIDTH         = 2,
  parameter int INIT_OFFSET       = 0,
  parameter int SLIP_GUARD_CYCLES = 0
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  bitslip,
  input  logic                  cfg_hdr_err,
  output logic [DATA_WIDTH-1:0] serdes_rx_data,
  output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
  output logic [6:0]            slip_offset,
  output logic [15:0]           slip_count
);

  // state         | meaning
  // LOCKED_OFFSET | guard_cnt == 0, bitslip rising edges are accepted
  // GUARD         | guard_cnt > 0, bitslip rising edges are discarded

  localparam int BW = DATA_WIDTH + HDR_WIDTH;
  localparam int GW = (SLIP_GUARD_CYCLES > 0) ? $clog2(SLIP_GUARD_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GUARD_LOAD  = GW'(SLIP_GUARD_CYCLES);
  localparam logic [6:0]    LAST_OFFSET = 7'(BW - 1);
  localparam logic [6:0]    RST_OFFSET  = 7'(INIT_OFFSET);

  typedef enum logic {
    LOCKED_OFFSET = 1'b0,
    GUARD         = 1'b1
  } state_t;

  state_t           state;
  logic [GW-1:0]    guard_cnt;
  logic             bitslip_d;
  logic [BW-1:0]    prev_reg;
  logic [BW-1:0]    cur_blk;
  logic [2*BW-1:0]  stream;
  logic [BW-1:0]    window;
  logic             slip_rise;
  logic             slip_accept;

  assign cur_blk     = {in_data, in_hdr};
  assign stream      = {cur_blk, prev_reg};
  assign slip_rise   = bitslip & ~bitslip_d;
  assign slip_accept = slip_rise & (state == LOCKED_OFFSET);

  // Bit 0 of prev_reg is the earliest bit still held in the two-block span.
  always_comb begin
    window = stream[slip_offset +: BW];
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      prev_reg       <= '0;
      serdes_rx_data <= '0;
      serdes_rx_hdr  <= '0;
      bitslip_d      <= 1'b0;
    end else begin
      prev_reg       <= cur_blk;
      serdes_rx_data <= window[BW-1:HDR_WIDTH];
      serdes_rx_hdr  <= cfg_hdr_err ? '0 : window[HDR_WIDTH-1:0];
      bitslip_d      <= bitslip;
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state       <= LOCKED_OFFSET;
      guard_cnt   <= '0;
      slip_offset <= RST_OFFSET;
      slip_count  <= '0;
    end else begin
      case (state)
        LOCKED_OFFSET: begin
          if (slip_accept) begin
            slip_offset <= (slip_offset == LAST_OFFSET) ? 7'd0 : slip_offset + 7'd1;
            if (slip_count != 16'hFFFF) slip_count <= slip_count + 16'd1;
            guard_cnt   <= GUARD_LOAD;
            state       <= (SLIP_GUARD_CYCLES > 0) ? GUARD : LOCKED_OFFSET;
          end
        end
        GUARD: begin
          // Leaving on the last decrement lets a rising edge on the very next
          // edge (guard_cnt sampled as 0) be accepted.
          guard_cnt <= guard_cnt - GW'(1);
          if (guard_cnt == GW'(1)) state <= LOCKED_OFFSET;
        end
        default: begin
          state     <= LOCKED_OFFSET;
          guard_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_rx_bitslip_aligner.sv
// Randomized scoreboard bench: two aligners (no guard / 8-cycle guard, offsets 0 / 2)
// share one stimulus stream and are checked against a bit-level reference model.
module tb_serdes_rx_bitslip_aligner;

  logic        rx_clk = 1'b0;
  logic        rx_rst = 1'b1;
  logic [63:0] in_data = '0;
  logic [1:0]  in_hdr = '0;
  logic        bitslip = 1'b0;
  logic        cfg_hdr_err = 1'b0;

  logic [63:0] data0, data1;
  logic [1:0]  hdr0, hdr1;
  logic [6:0]  off0, off1;
  logic [15:0] cnt0, cnt1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 rx_clk = ~rx_clk;

  serdes_rx_bitslip_aligner #(.INIT_OFFSET(0), .SLIP_GUARD_CYCLES(0)) dut0 (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .in_data(in_data), .in_hdr(in_hdr),
    .bitslip(bitslip), .cfg_hdr_err(cfg_hdr_err), .serdes_rx_data(data0),
    .serdes_rx_hdr(hdr0), .slip_offset(off0), .slip_count(cnt0));

  serdes_rx_bitslip_aligner #(.INIT_OFFSET(2), .SLIP_GUARD_CYCLES(8)) dut1 (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .in_data(in_data), .in_hdr(in_hdr),
    .bitslip(bitslip), .cfg_hdr_err(cfg_hdr_err), .serdes_rx_data(data1),
    .serdes_rx_hdr(hdr1), .slip_offset(off1), .slip_count(cnt1));

  typedef struct {
    logic [63:0] d0, d1;
    logic [1:0]  h0, h1;
    logic [6:0]  o0, o1;
    logic [15:0] c0, c1;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain integers and a bit-by-bit stream view.
  int          m_init[2]  = '{0, 2};
  int          m_gcyc[2]  = '{0, 8};
  int          m_off[2];
  int          m_cnt[2];
  int          m_guard[2];
  logic [65:0] m_prev_blk;
  bit          m_prev_bs;
  bit          rel_pending = 0;

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_off[j] = m_init[j];
      m_cnt[j] = 0;
      m_guard[j] = 0;
    end
    m_prev_blk = '0;
    m_prev_bs  = 0;
  endtask

  function automatic logic [65:0] take_window(logic [65:0] cur, logic [65:0] prev, int off);
    logic [131:0] s;
    logic [65:0]  w;
    for (int i = 0; i < 132; i++) s[i] = (i < 66) ? prev[i] : cur[i-66];
    for (int i = 0; i < 66; i++) w[i] = s[off+i];
    return w;
  endfunction

  function automatic exp_t model_step(logic [65:0] blk, bit bs, bit err);
    exp_t e;
    logic [65:0] w[2];
    bit rise = bs && !m_prev_bs;
    for (int j = 0; j < 2; j++) begin
      w[j] = take_window(blk, m_prev_blk, m_off[j]);
      if (rise && m_guard[j] == 0) begin
        m_off[j] = (m_off[j] + 1) % 66;
        if (m_cnt[j] < 65535) m_cnt[j]++;
        m_guard[j] = m_gcyc[j];
      end else if (m_guard[j] > 0) begin
        m_guard[j]--;
      end
    end
    e.d0 = w[0][65:2];
    e.d1 = w[1][65:2];
    e.h0 = err ? 2'b00 : w[0][1:0];
    e.h1 = err ? 2'b00 : w[1][1:0];
    e.o0 = 7'(m_off[0]);
    e.o1 = 7'(m_off[1]);
    e.c0 = 16'(m_cnt[0]);
    e.c1 = 16'(m_cnt[1]);
    m_prev_blk = blk;
    m_prev_bs  = bs;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, queue the expected response.
  task automatic step(logic [63:0] d, logic [1:0] h, bit bs, bit err);
    @(negedge rx_clk);
    if (rel_pending) begin
      rx_rst = 1'b0;
      rel_pending = 0;
    end
    in_data     = d;
    in_hdr      = h;
    bitslip     = bs;
    cfg_hdr_err = err;
    exp_q.push_back(model_step({d, h}, bs, err));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic rnd_step(bit bs, bit err);
    step(rnd64(), 2'($urandom_range(0, 3)), bs, err);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge rx_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("d0_data", data0, e.d0);
        chk("d0_hdr", 64'(hdr0), 64'(e.h0));
        chk("d0_offset", 64'(off0), 64'(e.o0));
        chk("d0_count", 64'(cnt0), 64'(e.c0));
        chk("d1_data", data1, e.d1);
        chk("d1_hdr", 64'(hdr1), 64'(e.h1));
        chk("d1_offset", 64'(off1), 64'(e.o1));
        chk("d1_count", 64'(cnt1), 64'(e.c1));
      end
    end
  end

  task automatic check_reset_values(string tag);
    chk({tag, "_d0_data"}, data0, 64'd0);
    chk({tag, "_d0_hdr"}, 64'(hdr0), 64'd0);
    chk({tag, "_d0_offset"}, 64'(off0), 64'd0);
    chk({tag, "_d0_count"}, 64'(cnt0), 64'd0);
    chk({tag, "_d1_data"}, data1, 64'd0);
    chk({tag, "_d1_hdr"}, 64'(hdr1), 64'd0);
    chk({tag, "_d1_offset"}, 64'(off1), 64'd2);
    chk({tag, "_d1_count"}, 64'(cnt1), 64'd0);
  endtask

  initial begin : stim
    logic [63:0] cd;
    int need;
    cd = 64'h0123456789ABCDEF;
    model_reset();
    repeat (3) @(negedge rx_clk);
    check_reset_values("reset");

    // Constant block: offset 0 reproduces it, offset 2 rotates by two bits.
    rel_pending = 1;
    repeat (5) step(cd, 2'b01, 0, 0);

    // 66 single-cycle pulses, 3 cycles apart: full offset wrap on dut0.
    for (int p = 0; p < 66; p++) begin
      rnd_step(1, 0);
      rnd_step(0, 0);
      rnd_step(0, 0);
    end
    repeat (3) step(cd, 2'b01, 0, 0);

    // Level held high for 5 cycles yields one slip.
    repeat (5) rnd_step(1, 0);
    repeat (10) rnd_step(0, 0);

    // Guard window: pulses at relative cycles 0, 4 and 9.
    for (int c = 0; c < 14; c++) rnd_step(c == 0 || c == 4 || c == 9, 0);
    repeat (4) rnd_step(0, 0);

    // Forced bad headers for 3 cycles.
    repeat (3) rnd_step(0, 1);
    repeat (3) rnd_step(0, 0);

    // Random mix of slips and header forcing.
    for (int c = 0; c < 300; c++)
      rnd_step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    repeat (3) rnd_step(0, 0);

    // Walk dut0 to offset 17, then reset mid-stream.
    need = (17 - m_off[0] + 66) % 66;
    for (int p = 0; p < need; p++) begin
      rnd_step(1, 0);
      rnd_step(0, 0);
    end
    repeat (2) rnd_step(0, 0);
    @(posedge rx_clk);
    #2;
    chk("pre_reset_d0_offset", 64'(off0), 64'd17);
    rx_rst = 1'b1;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(negedge rx_clk);
    rel_pending = 1;
    // Bitslip high on the first edge after release counts as a rising edge.
    rnd_step(1, 0);
    repeat (20) rnd_step($urandom_range(0, 2) == 0, 0);

    @(posedge rx_clk);
    #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
